// File: rtl/button_conditioner.sv
// Button conditioner for the Simon game front end.
// Synchronizes a bouncy push button and four pattern switches, debounces
// both the press and the release, and emits a single fixed-width pclk pulse
// per accepted press together with a switch snapshot and a press counter.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PULSE_CYCLES    = 4
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic [3:0] sw_raw,
  output logic       pclk,
  output logic [3:0] pattern,
  output logic [7:0] press_count
);

  localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_CHK = 3'd1,
    PULSE     = 3'd2,
    HELD      = 3'd3,
    REL_CHK   = 3'd4
  } state_t;

  logic       r_btnMeta;
  logic       r_btnSync;
  logic [3:0] r_swMeta;
  logic [3:0] r_swSync;

  state_t      r_state;
  state_t      w_stateNext;
  logic [15:0] r_cnt;
  logic [15:0] w_cntNext;
  logic        w_accept;
  logic        w_pclkNext;

  logic       r_pclk;
  logic [3:0] r_pattern;
  logic [7:0] r_pressCount;

  // Two-flop synchronizers bring the asynchronous button and switches into the sysclk domain.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_btnMeta <= 1'b0;
      r_btnSync <= 1'b0;
      r_swMeta  <= 4'b0000;
      r_swSync  <= 4'b0000;
    end else begin
      r_btnMeta <= btn_raw;
      r_btnSync <= r_btnMeta;
      r_swMeta  <= sw_raw;
      r_swSync  <= r_swMeta;
    end
  end

  // State register and shared stable/pulse counter.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Next-state logic: the counter measures stable cycles in the check states and pulse width in PULSE.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_btnSync) begin
          w_stateNext = PRESS_CHK;
          w_cntNext   = 16'd0;
        end
      end
      PRESS_CHK: begin
        if (!r_btnSync) begin
          w_stateNext = IDLE;
          w_cntNext   = 16'd0;
        end else if (r_cnt == DEB_LAST) begin
          w_stateNext = PULSE;
          w_cntNext   = 16'd0;
          w_accept    = 1'b1;
        end else begin
          w_cntNext = r_cnt + 16'd1;
        end
      end
      PULSE: begin
        if (r_cnt == PULSE_LAST) begin
          w_stateNext = HELD;
          w_cntNext   = 16'd0;
        end else begin
          w_cntNext = r_cnt + 16'd1;
        end
      end
      HELD: begin
        if (!r_btnSync) begin
          w_stateNext = REL_CHK;
          w_cntNext   = 16'd0;
        end
      end
      REL_CHK: begin
        if (r_btnSync) begin
          w_stateNext = HELD;
          w_cntNext   = 16'd0;
        end else if (r_cnt == DEB_LAST) begin
          w_stateNext = IDLE;
          w_cntNext   = 16'd0;
        end else begin
          w_cntNext = r_cnt + 16'd1;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = 16'd0;
      end
    endcase
  end

  // Output decode: pclk is registered from the next state so it is high exactly while the FSM sits in PULSE.
  always_comb begin
    w_pclkNext = (w_stateNext == PULSE);
  end

  // Output registers: the switch snapshot and press count only move when a press is accepted.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_pclk       <= 1'b0;
      r_pattern    <= 4'b0000;
      r_pressCount <= 8'd0;
    end else begin
      r_pclk <= w_pclkNext;
      if (w_accept) begin
        r_pattern    <= r_swSync;
        r_pressCount <= r_pressCount + 8'd1;
      end
    end
  end

  assign pclk        = r_pclk;
  assign pattern     = r_pattern;
  assign press_count = r_pressCount;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner with DEBOUNCE_CYCLES=4, PULSE_CYCLES=2.
// Expected pulses (rise cycle, pattern, count, width) are queued as presses are
// driven; a negedge monitor matches them against the pulses the DUT produces.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int PUL = 2;
  localparam int RISE_OFFSET = 1 + DEB + 2;

  typedef struct {
    int         riseCyc;
    logic [3:0] pat;
    logic [7:0] cnt;
    int         width;
  } expect_t;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic [3:0] sw_raw = 4'b0000;
  logic       pclk;
  logic [3:0] pattern;
  logic [7:0] press_count;

  int passChecks = 0;
  int totalChecks = 0;
  int cyc = 0;
  int pulseCount = 0;
  int highLen = 0;
  logic prevPclk = 1'b0;
  logic [7:0] expCount = 8'd0;
  logic [3:0] expPattern = 4'b0000;
  expect_t sbQ[$];

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES(PUL)
  ) dut (
    .sysclk(sysclk),
    .rst(rst),
    .btn_raw(btn_raw),
    .sw_raw(sw_raw),
    .pclk(pclk),
    .pattern(pattern),
    .press_count(press_count)
  );

  // 10 ns clock and a running edge counter used to timestamp pulses.
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    assert (obs === exp) passChecks++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic btn, input logic [3:0] sw, input int n);
    btn_raw = btn;
    sw_raw  = sw;
    repeat (n) @(negedge sysclk);
  endtask

  // Queue the pulse a press starting on the next edge should produce.
  task automatic pressExpect(input logic [3:0] sw, input int width);
    expect_t e;
    expCount   = expCount + 8'd1;
    expPattern = sw;
    e.riseCyc  = cyc + RISE_OFFSET;
    e.pat      = sw;
    e.cnt      = expCount;
    e.width    = width;
    sbQ.push_back(e);
  endtask

  // Pulse monitor: checks timing, snapshot and count on each rise, width on each fall.
  always @(negedge sysclk) begin
    if (pclk === 1'b1 && prevPclk !== 1'b1) begin
      pulseCount++;
      highLen = 1;
      if (sbQ.size() == 0) begin
        checkOutput("sb_unexpected_pulse", 32'(sbQ.size()), 32'd1);
      end else begin
        checkOutput("sb_rise_cycle", cyc, sbQ[0].riseCyc);
        checkOutput("sb_pattern", {28'd0, pattern}, {28'd0, sbQ[0].pat});
        checkOutput("sb_count", {24'd0, press_count}, {24'd0, sbQ[0].cnt});
      end
    end else if (pclk === 1'b1) begin
      highLen++;
    end else if (prevPclk === 1'b1) begin
      if (sbQ.size() != 0) begin
        checkOutput("sb_width", highLen, sbQ[0].width);
        void'(sbQ.pop_front());
      end
    end
    prevPclk <= pclk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulsesBefore;
    logic [5:0] bouncePat;
    logic [3:0] rsw;

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, 4'b0000, 3);
    checkOutput("reset_pclk", {31'd0, pclk}, 32'd0);
    checkOutput("reset_pattern", {28'd0, pattern}, 32'd0);
    checkOutput("reset_count", {24'd0, press_count}, 32'd0);
    checkOutput("reset_state", {29'd0, dut.r_state}, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 4'b0000, 2);

    // Clean press with per-edge pclk/pattern checks
    pressExpect(4'b1010, PUL);
    btn_raw = 1'b1;
    sw_raw  = 4'b1010;
    for (int ed = 0; ed <= 8; ed++) begin
      @(negedge sysclk);
      checkOutput($sformatf("clean_pclk_e%0d", ed), {31'd0, pclk},
                  (ed == 6 || ed == 7) ? 32'd1 : 32'd0);
      checkOutput($sformatf("clean_pattern_e%0d", ed), {28'd0, pattern},
                  (ed >= 6) ? 32'hA : 32'h0);
    end
    checkOutput("clean_count", {24'd0, press_count}, 32'd1);
    applyStimulus(1'b1, 4'b1010, 3);
    applyStimulus(1'b0, 4'b1010, 8);

    // Bounce rejection with a different switch value present
    pulsesBefore = pulseCount;
    bouncePat = 6'b011011;
    for (int i = 0; i < 12; i++) applyStimulus(bouncePat[i % 6], 4'b0101, 1);
    applyStimulus(1'b0, 4'b0101, 10);
    checkOutput("bounce_pulses", pulseCount, pulsesBefore);
    checkOutput("bounce_pattern", {28'd0, pattern}, 32'hA);
    checkOutput("bounce_count", {24'd0, press_count}, 32'd1);

    // Long hold with switch change while held
    pulsesBefore = pulseCount;
    pressExpect(4'b0011, PUL);
    applyStimulus(1'b1, 4'b0011, 20);
    applyStimulus(1'b1, 4'b1100, 80);
    checkOutput("hold_pulses", pulseCount, pulsesBefore + 1);
    checkOutput("hold_state", {29'd0, dut.r_state}, 32'd3);
    checkOutput("hold_pattern", {28'd0, pattern}, 32'h3);
    applyStimulus(1'b0, 4'b1100, 8);
    checkOutput("isolate_pattern", {28'd0, pattern}, 32'h3);
    checkOutput("isolate_count", {24'd0, press_count}, 32'd2);
    pressExpect(4'b1100, PUL);
    applyStimulus(1'b1, 4'b1100, 12);
    checkOutput("next_pattern", {28'd0, pattern}, 32'hC);
    checkOutput("next_count", {24'd0, press_count}, 32'd3);
    applyStimulus(1'b0, 4'b1100, 8);

    // Release bounce: 0,0,1 then steady 0
    pressExpect(4'b0110, PUL);
    applyStimulus(1'b1, 4'b0110, 12);
    pulsesBefore = pulseCount;
    applyStimulus(1'b0, 4'b0110, 2);
    applyStimulus(1'b1, 4'b0110, 1);
    applyStimulus(1'b0, 4'b0110, 6);
    checkOutput("relbounce_still_chk", {29'd0, dut.r_state}, 32'd4);
    applyStimulus(1'b0, 4'b0110, 1);
    checkOutput("relbounce_idle", {29'd0, dut.r_state}, 32'd0);
    applyStimulus(1'b0, 4'b0110, 4);
    checkOutput("relbounce_pulses", pulseCount, pulsesBefore);

    // Reset on the first pclk-high cycle, button kept held through reset
    pressExpect(4'b1001, 1);
    applyStimulus(1'b1, 4'b1001, RISE_OFFSET);
    checkOutput("midpulse_pclk_high", {31'd0, pclk}, 32'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 4'b1001, 1);
    checkOutput("midpulse_pclk", {31'd0, pclk}, 32'd0);
    checkOutput("midpulse_pattern", {28'd0, pattern}, 32'd0);
    checkOutput("midpulse_count", {24'd0, press_count}, 32'd0);
    expCount = 8'd0;
    expPattern = 4'b0000;
    rst = 1'b0;
    pressExpect(4'b1001, PUL);
    applyStimulus(1'b1, 4'b1001, 12);
    checkOutput("redetect_count", {24'd0, press_count}, 32'd1);
    applyStimulus(1'b0, 4'b1001, 8);

    // Counter wrap: 256 presses from reset with random switch snapshots
    rst = 1'b1;
    applyStimulus(1'b0, 4'b0000, 2);
    rst = 1'b0;
    expCount = 8'd0;
    for (int p = 0; p < 256; p++) begin
      rsw = 4'($urandom_range(0, 15));
      pressExpect(rsw, PUL);
      applyStimulus(1'b1, rsw, 12);
      applyStimulus(1'b0, rsw, 8);
    end
    checkOutput("wrap_count", {24'd0, press_count}, {24'd0, expCount});
    checkOutput("wrap_count_zero", {24'd0, press_count}, 32'd0);
    checkOutput("wrap_pattern", {28'd0, pattern}, {28'd0, expPattern});

    applyStimulus(1'b0, 4'b0000, 4);
    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
